load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit sitting directly downstream of the ALU in the single-cycle CPU. It consumes the ALU result as the effective address and drives a req/grant data-memory bus. It handles byte/halfword/word lanes, sign/zero extension and bus timeout, and stalls the core while a memory access is in flight.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent in REQ+WAIT before abort; 0 disables the timeout.
- `clk`  in  1  sole clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `memOp`  in  4  operation code: MEMOP_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- `memStart`  in  1  control asserts this for the whole duration of a load/store instruction.
- `aluOut`  in  `DATALENGTH`  effective byte address.
- `storeData`  in  `DATALENGTH`  store source register value.
- `stall`  out  1  holds PC and register-file write.
- `loadData`  out  `DATALENGTH`  extended load result.
- `loadValid`  out  1  one-cycle writeback strobe for loads.
- `busReq`  out  1  request.
- `busWe`  out  1  write.
- `busAddr`  out  `DATALENGTH`  word-aligned address, bits [1:0] = 0.
- `busBe`  out  4  byte enables.
- `busWdata`  out  `DATALENGTH`  write data.
- `busGnt`  in  1  request accepted this cycle.
- `busRvalid`  in  1  read data valid.
- `busRdata`  in  `DATALENGTH`  read data.
- `busErr`  out  1  one-cycle timeout pulse.
- `misalign`  out  1  one-cycle misaligned-access pulse; see Configuration.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - `memStart` with `memOp` ≠ NONE: latch op, address and store data, then go to REQ. If the access is misaligned and the macro is enabled, go straight to DONE instead.
  - `memOp` = NONE: no action.
- **REQ**
  - `busReq` = 1. Address, `busWe`, `busBe` and `busWdata` come from latched values and are stable until grant.
  - `busGnt` on a store: go to DONE.
  - `busGnt` on a load: go to WAIT. If `busRvalid` is also high in the same cycle, capture the data and go straight to DONE.
  - `busRvalid` without `busGnt` is ignored.
- **WAIT**
  - `busRvalid`: capture the extended data and go to DONE.
- **DONE**
  - Go to IDLE unconditionally.
  - `loadValid` = 1 for a successful load only.
  - `memStart` is ignored here; the next instruction is sampled back in IDLE.
- **Stall**: `stall` = (IDLE & `memStart` & `memOp` ≠ NONE) | REQ | WAIT. `stall` is 0 in DONE.
- **Byte lanes** (little-endian, `a` = address[1:0]):
  - SB: `busBe` = 1<<`a`; `busWdata` = byte replicated ×4.
  - SH: `busBe` = `a`[1] ? 1100 : 0011; `busWdata` = halfword replicated ×2.
  - SW: `busBe` = 1111.
  - Loads: `busBe` = 1111. Select the byte/halfword by `a`; sign-extend LB/LH, zero-extend LBU/LHU.
- **Timeout**: counter cleared on entry to REQ, counts every cycle in REQ/WAIT. On reaching `TIMEOUT`-1 without completion: go to DONE, `busErr` = 1, `loadData` = 0, no `loadValid`.
- **Reset mid-operation**: the in-flight transaction is abandoned. A late `busRvalid` seen in IDLE is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- Store with immediate grant: latch at cycle 0, REQ at cycle 1, DONE at cycle 2. `stall` is high for cycles 0–1.
- Load, grant at cycle 1, rvalid at cycle 2: DONE at cycle 3. `loadValid` and `loadData` are valid at cycle 3.
- `loadData` holds its value until the next load completes.
- Pulses (`loadValid`, `busErr`, `misalign`) are registered outputs, high exactly one cycle, in DONE.

## Configuration
- Macro: `LSU_MISALIGN_EXC_EN`.
- Defined:
  - LH/LHU/SH with address[0] = 1, or LW/SW with address[1:0] ≠ 0, go IDLE to DONE.
  - No bus request; `misalign` pulses; no `loadValid`.
- Undefined:
  - Offending low bits are ignored: halfword uses address[1], word uses the aligned word.
  - The access proceeds normally and `misalign` is tied to 0.

## Structure
- `defines.vh` holds:
  - MEMOP_* codes and MEMOP_SIZE;
  - LSU state encodings;
  - reuse of `DATALENGTH` and `ZEROWORD`.
- Sub-module `lsu_lane`: combinational byte-enable, write-data replication and load extract/extend logic. The FSM and counter stay in `load_store_unit`.

## Test plan
- SB, `aluOut`=0x1003, `storeData`=0x000000A5, grant at cycle 1 -> `busAddr`=0x1000, `busBe`=1000, `busWdata`=0xA5A5A5A5; `stall` high 2 cycles.
- LB at 0x2001, `busRdata`=0x00008000 on rvalid -> `loadData`=0xFFFFFF80, `loadValid` single pulse. LBU at the same address -> 0x00000080.
- LW with `busGnt` and `busRvalid` in the same cycle, data 0xDEADBEEF -> DONE next cycle, `loadData`=0xDEADBEEF.
- `TIMEOUT`=8, load, grant never asserted -> `busErr` pulse at cycle 8, `loadData`=0, no `loadValid`, `stall` drops.
- LH at 0x3001 -> with the macro: `misalign` pulse, `busReq` never high; without the macro: halfword [15:0] read.
- `rstn` low while in WAIT, then `busRvalid` arrives -> state IDLE, all outputs 0, no `loadValid`.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
//------------------------------------------------------------------------------
// Module   : load_store_unit_pkg
// Brief    : Shared widths, memory-op codes, LSU state encoding and op helpers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package load_store_unit_pkg;

  localparam int DATALENGTH = 32;
  localparam logic [DATALENGTH-1:0] ZEROWORD = '0;

  localparam int MEMOP_SIZE = 4;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_NONE = 4'd0;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_LB   = 4'd1;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_LBU  = 4'd2;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_LH   = 4'd3;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_LHU  = 4'd4;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_LW   = 4'd5;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_SB   = 4'd6;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_SH   = 4'd7;
  localparam logic [MEMOP_SIZE-1:0] MEMOP_SW   = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  function automatic logic op_is_load(input logic [MEMOP_SIZE-1:0] op);
    return (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_LH) ||
           (op == MEMOP_LHU) || (op == MEMOP_LW);
  endfunction

  function automatic logic op_is_store(input logic [MEMOP_SIZE-1:0] op);
    return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
  endfunction

  function automatic logic op_misaligned(input logic [MEMOP_SIZE-1:0] op,
                                         input logic [1:0]            a);
    logic r;
    r = 1'b0;
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: r = a[0];
      MEMOP_LW, MEMOP_SW:            r = (a != 2'b00);
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_lane.sv
//------------------------------------------------------------------------------
// Module   : lsu_lane
// Brief    : Byte-enable generation, store-data replication, load extract/extend.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_lane
  import load_store_unit_pkg::*;
(
  input  logic [MEMOP_SIZE-1:0] op_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [DATALENGTH-1:0] store_data_i,
  input  logic [DATALENGTH-1:0] rdata_i,
  output logic [3:0]            be_o,
  output logic [DATALENGTH-1:0] wdata_o,
  output logic [DATALENGTH-1:0] load_data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    case (op_i)
      MEMOP_SB: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      MEMOP_SH: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Halfword selection only looks at address bit 1; bit 0 is dropped.
  always_comb begin
    w_byte = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    load_data_o = rdata_i;
    case (op_i)
      MEMOP_LB:  load_data_o = {{24{w_byte[7]}}, w_byte};
      MEMOP_LBU: load_data_o = {24'd0, w_byte};
      MEMOP_LH:  load_data_o = {{16{w_half[15]}}, w_half};
      MEMOP_LHU: load_data_o = {16'd0, w_half};
      default:   load_data_o = rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// Module   : load_store_unit
// Brief    : Multi-cycle load/store unit driving a req/grant data-memory bus.
//            Optional misaligned-access exception: LSU_MISALIGN_EXC_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [MEMOP_SIZE-1:0] memOp,
  input  logic                  memStart,
  input  logic [DATALENGTH-1:0] aluOut,
  input  logic [DATALENGTH-1:0] storeData,
  output logic                  stall,
  output logic [DATALENGTH-1:0] loadData,
  output logic                  loadValid,
  output logic                  busReq,
  output logic                  busWe,
  output logic [DATALENGTH-1:0] busAddr,
  output logic [3:0]            busBe,
  output logic [DATALENGTH-1:0] busWdata,
  input  logic                  busGnt,
  input  logic                  busRvalid,
  input  logic [DATALENGTH-1:0] busRdata,
  output logic                  busErr,
  output logic                  misalign
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  lsu_state_e            state_q, state_d;
  logic [MEMOP_SIZE-1:0] op_q, op_d;
  logic [DATALENGTH-1:0] addr_q, addr_d;
  logic [DATALENGTH-1:0] sdata_q, sdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATALENGTH-1:0] load_data_q, load_data_d;
  logic                  load_valid_q, load_valid_d;
  logic                  bus_err_q, bus_err_d;
`ifdef LSU_MISALIGN_EXC_EN
  logic                  misalign_q, misalign_d;
`endif

  logic                  w_start;
  logic                  w_in_req;
  logic [31:0]           w_cnt_inc;
  logic                  w_timeout;
  logic [3:0]            w_be;
  logic [DATALENGTH-1:0] w_wdata;
  logic [DATALENGTH-1:0] w_ldata;

  lsu_lane u_lane (
    .op_i         (op_q),
    .addr_lo_i    (addr_q[1:0]),
    .store_data_i (sdata_q),
    .rdata_i      (busRdata),
    .be_o         (w_be),
    .wdata_o      (w_wdata),
    .load_data_o  (w_ldata)
  );

  assign w_start   = memStart && (op_is_load(memOp) || op_is_store(memOp));
  assign w_in_req  = (state_q == S_REQ);
  assign w_cnt_inc = 32'(cnt_q) + 32'd1;
  // Abort is decided one cycle ahead so DONE lands on cycle TIMEOUT.
  assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc >= (TIMEOUT - 32'd1));

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    sdata_d      = sdata_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    misalign_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          op_d    = memOp;
          addr_d  = aluOut;
          sdata_d = storeData;
          cnt_d   = '0;
          state_d = S_REQ;
`ifdef LSU_MISALIGN_EXC_EN
          if (op_misaligned(memOp, aluOut[1:0])) begin
            state_d    = S_DONE;
            misalign_d = 1'b1;
          end
`endif
        end
      end
      S_REQ: begin
        if (TIMEOUT != 0) cnt_d = CNT_W'(w_cnt_inc);
        if (busGnt && op_is_store(op_q)) begin
          state_d = S_DONE;
        end else if (busGnt && busRvalid) begin
          state_d      = S_DONE;
          load_data_d  = w_ldata;
          load_valid_d = 1'b1;
        end else if (w_timeout) begin
          state_d     = S_DONE;
          bus_err_d   = 1'b1;
          load_data_d = ZEROWORD;
        end else if (busGnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (TIMEOUT != 0) cnt_d = CNT_W'(w_cnt_inc);
        if (busRvalid) begin
          state_d      = S_DONE;
          load_data_d  = w_ldata;
          load_valid_d = 1'b1;
        end else if (w_timeout) begin
          state_d     = S_DONE;
          bus_err_d   = 1'b1;
          load_data_d = ZEROWORD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      op_q         <= MEMOP_NONE;
      addr_q       <= ZEROWORD;
      sdata_q      <= ZEROWORD;
      cnt_q        <= '0;
      load_data_q  <= ZEROWORD;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      sdata_q      <= sdata_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
`ifdef LSU_MISALIGN_EXC_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign stall     = ((state_q == S_IDLE) && w_start) || (state_q == S_REQ) ||
                     (state_q == S_WAIT);
  assign loadData  = load_data_q;
  assign loadValid = load_valid_q;
  assign busErr    = bus_err_q;
  // Bus fields are only driven while a request is outstanding.
  assign busReq    = w_in_req;
  assign busWe     = w_in_req && op_is_store(op_q);
  assign busAddr   = w_in_req ? {addr_q[DATALENGTH-1:2], 2'b00} : ZEROWORD;
  assign busBe     = w_in_req ? w_be : 4'b0000;
  assign busWdata  = w_in_req ? w_wdata : ZEROWORD;
`ifdef LSU_MISALIGN_EXC_EN
  assign misalign  = misalign_q;
`else
  assign misalign  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_load_store_unit
// Brief    : Self-checking bench for load_store_unit (directed + random accesses).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  memOp;
  logic        memStart;
  logic [31:0] aluOut, storeData;
  logic        stall, loadValid, busReq, busWe, busGnt, busRvalid, busErr, misalign;
  logic [31:0] loadData, busAddr, busWdata, busRdata;
  logic [3:0]  busBe;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_ld = 32'd0;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .memOp(memOp), .memStart(memStart), .aluOut(aluOut),
    .storeData(storeData), .stall(stall), .loadData(loadData), .loadValid(loadValid),
    .busReq(busReq), .busWe(busWe), .busAddr(busAddr), .busBe(busBe),
    .busWdata(busWdata), .busGnt(busGnt), .busRvalid(busRvalid), .busRdata(busRdata),
    .busErr(busErr), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_ldata"}, loadData, 0);
    chk({tag, "_lvalid"}, loadValid, 0);
    chk({tag, "_req"}, busReq, 0);
    chk({tag, "_we"}, busWe, 0);
    chk({tag, "_addr"}, busAddr, 0);
    chk({tag, "_be"}, busBe, 0);
    chk({tag, "_wdata"}, busWdata, 0);
    chk({tag, "_err"}, busErr, 0);
    chk({tag, "_mis"}, misalign, 0);
  endtask

  // One instruction: grant after g REQ cycles, rvalid r cycles after grant.
  task automatic access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int g, input int r);
    bit          ld, st, mis, tmo, in_req;
    int          d, done;
    logic [1:0]  a;
    logic [31:0] bv, hv, val, ebe, ewd;
    ld  = (op >= MEMOP_LB) && (op <= MEMOP_LW);
    st  = (op >= MEMOP_SB) && (op <= MEMOP_SW);
    a   = addr[1:0];
    mis = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    mis = ((op == MEMOP_LH || op == MEMOP_LHU || op == MEMOP_SH) && a[0]) ||
          ((op == MEMOP_LW || op == MEMOP_SW) && a != 2'd0);
`endif
    d    = st ? 1 + g : 1 + g + r;
    tmo  = !mis && (d > int'(TMO) - 1);
    done = mis ? 1 : (tmo ? int'(TMO) : d + 1);

    bv = (rdata >> (8 * a)) & 32'hFF;
    hv = (rdata >> ((a >= 2'd2) ? 16 : 0)) & 32'hFFFF;
    case (op)
      MEMOP_LB:  val = (bv >= 128) ? bv - 32'd256 : bv;
      MEMOP_LBU: val = bv;
      MEMOP_LH:  val = (hv >= 32768) ? hv - 32'd65536 : hv;
      MEMOP_LHU: val = hv;
      default:   val = rdata;
    endcase
    case (op)
      MEMOP_SB: begin ebe = 32'd1 << a;           ewd = (sdata & 32'hFF) * 32'h01010101; end
      MEMOP_SH: begin ebe = 32'd3 << (a & 2'd2);  ewd = (sdata & 32'hFFFF) * 32'h00010001; end
      default:  begin ebe = 32'hF;                ewd = sdata; end
    endcase

    memStart = 1'b1; memOp = op; aluOut = addr; storeData = sdata;
    busGnt = 1'b0; busRvalid = 1'b0; busRdata = $urandom;
    @(negedge clk);
    chk({tag, "_c0_stall"}, stall, 1);
    chk({tag, "_c0_req"}, busReq, 0);
    tick();
    for (int c = 1; c < done; c++) begin
      busGnt    = (c == 1 + g);
      busRvalid = ld && (c == 1 + g + r);
      busRdata  = busRvalid ? rdata : $urandom;
      if (ld && g > 0 && c == 1) busRvalid = 1'b1;  // ignored: no grant yet
      in_req = (c <= 1 + g);
      @(negedge clk);
      chk({tag, "_stall"}, stall, 1);
      chk({tag, "_req"}, busReq, in_req);
      if (in_req) begin
        chk({tag, "_addr"}, busAddr, addr & ~32'h3);
        chk({tag, "_we"}, busWe, st);
        chk({tag, "_be"}, busBe, ebe);
        if (st) chk({tag, "_wdata"}, busWdata, ewd);
      end
      tick();
    end
    busGnt = 1'b0; busRvalid = 1'b0;
    if (tmo) exp_ld = 32'd0;
    else if (ld && !mis) exp_ld = val;
    @(negedge clk);
    chk({tag, "_done_stall"}, stall, 0);
    chk({tag, "_done_req"}, busReq, 0);
    chk({tag, "_done_lvalid"}, loadValid, ld && !mis && !tmo);
    chk({tag, "_done_err"}, busErr, tmo);
    chk({tag, "_done_mis"}, misalign, mis);
    chk({tag, "_done_ldata"}, loadData, exp_ld);
    tick();
    memStart = 1'b0; memOp = MEMOP_NONE;
    @(negedge clk);
    chk({tag, "_post_lvalid"}, loadValid, 0);
    chk({tag, "_post_err"}, busErr, 0);
    chk({tag, "_post_mis"}, misalign, 0);
    chk({tag, "_post_stall"}, stall, 0);
    chk({tag, "_post_ldata"}, loadData, exp_ld);
    tick();
  endtask

  initial begin
    rstn = 1'b0; memStart = 1'b0; memOp = MEMOP_NONE; aluOut = 0; storeData = 0;
    busGnt = 1'b0; busRvalid = 1'b0; busRdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rstn = 1'b1;
    tick();

    access("sb",      MEMOP_SB,  32'h1003, 32'h000000A5, 32'h0,        0,   0);
    access("lb",      MEMOP_LB,  32'h2001, 32'h0,        32'h00008000, 0,   1);
    access("lbu",     MEMOP_LBU, 32'h2001, 32'h0,        32'h00008000, 0,   1);
    access("lw_same", MEMOP_LW,  32'h2000, 32'h0,        32'hDEADBEEF, 0,   0);
    access("lw_tmo",  MEMOP_LW,  32'h2004, 32'h0,        32'h12345678, 100, 0);
    access("lh_mis",  MEMOP_LH,  32'h3001, 32'h0,        32'h12348765, 1,   0);
    access("lhu_hi",  MEMOP_LHU, 32'h3002, 32'h0,        32'h9ABC1234, 2,   2);
    access("sh_hi",   MEMOP_SH,  32'h4002, 32'hFFFF5AA5, 32'h0,        1,   0);
    access("sw",      MEMOP_SW,  32'h4008, 32'hCAFEBABE, 32'h0,        3,   0);
    access("ld_edge", MEMOP_LW,  32'h500C, 32'h0,        32'h0BADF00D, 5,   0);
    access("ld_late", MEMOP_LB,  32'h5003, 32'h0,        32'hFF000000, 5,   1);
    access("st_tmo",  MEMOP_SB,  32'h6000, 32'h11,       32'h0,        7,   0);

    for (int i = 0; i < 60; i++) begin
      access("rnd", 4'($urandom_range(1, 8)), $urandom, $urandom, $urandom,
             ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3),
             $urandom_range(0, 2));
    end

    // Reset while waiting for read data; a late rvalid must be ignored.
    memStart = 1'b1; memOp = MEMOP_LW; aluOut = 32'h7000; storeData = 0;
    busGnt = 1'b0; busRvalid = 1'b0;
    @(negedge clk);
    tick();
    busGnt = 1'b1;
    @(negedge clk);
    chk("rst_req", busReq, 1);
    tick();
    busGnt = 1'b0; memStart = 1'b0; memOp = MEMOP_NONE;
    @(negedge clk);
    chk("rst_wait_stall", stall, 1);
    rstn = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_ld = 32'd0;
    busRvalid = 1'b1; busRdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rst_late_stall", stall, 0);
    chk("rst_late_req", busReq, 0);
    chk("rst_late_lvalid", loadValid, 0);
    tick();
    busRvalid = 1'b0;
    @(negedge clk);
    chk("rst_after_lvalid", loadValid, 0);
    chk("rst_after_ldata", loadData, exp_ld);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
